ex_dispatch: RTL
================

EX_DISPATCH -- requirements
Module: ex_dispatch

Interface
REQ-001 Parameter XLEN, default 32, datapath operand width.
REQ-002 Parameter TAG_W, default 4, width of tag and target fields.
REQ-003 Parameter OP_W, default 6, opcode width.
REQ-004 Parameter DEPTH, default 4, instruction buffer entries; power of two, >= 2.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_ce  input  1  toggle-type strobe from the ID/EX register; each change of level marks one new instruction.
REQ-008 in_unit  input  2  target unit: 0 ALU, 1 BRU, 2 LSU, 3 MUL.
REQ-009 in_val  input  2*XLEN  operand pair, {B,A}.
REQ-010 in_tag  input  TAG_W  source/ROB tag.
REQ-011 in_op  input  OP_W  opcode.
REQ-012 in_target  input  TAG_W  destination tag.
REQ-013 fu_ready  input  4  per-unit ready; bit index = unit code.
REQ-014 fu_valid  output  4  per-unit valid; at most one bit set.
REQ-015 fu_op, fu_val, fu_tag, fu_target  output  OP_W, 2*XLEN, TAG_W, TAG_W  head-entry payload, shared by all units.
REQ-016 stall  output  1  backpressure request to ID.
REQ-017 overflow  output  1  sticky error flag.
REQ-018 count  output  $clog2(DEPTH)+1  occupancy.

Function
REQ-019 The block keeps ce_q, a registered copy of in_ce. A new instruction is detected when in_ce != ce_q and primed = 1.
REQ-020 First cycle after reset: ce_q <= in_ce, primed <= 1, no enqueue. Prevents a spurious push from an unknown upstream ce level.
REQ-021 After priming, ce_q <= in_ce every cycle.
REQ-022 Detected instruction is written to the FIFO tail in the same edge: {unit, val, tag, op, target}. Latency from in_ce toggle to fu_valid = 1 cycle when the FIFO was empty.
REQ-023 Dispatch is in-order from the head only; no reordering across units.
REQ-024 fu_valid[head.unit] = 1 whenever count > 0; all other fu_valid bits = 0. fu_valid = 0 when empty.
REQ-025 Handshake: a dequeue occurs on an edge where fu_valid[u] & fu_ready[u]. fu_valid and payload stay stable until dequeue; fu_ready of other units is ignored.
REQ-026 Payload outputs are driven from the head entry whenever count > 0; value is don't-care when empty.
REQ-027 Simultaneous enqueue and dequeue: both take effect; count unchanged. This holds when count == DEPTH.
REQ-028 Enqueue when count == DEPTH with no dequeue in that cycle: entry dropped, overflow <= 1, count and pointers unchanged.
REQ-029 overflow is sticky until reset.
REQ-030 stall = 1 (registered) when count >= DEPTH-1 after the current edge's update, else 0. This leaves one slot for an instruction already in flight in ID/EX.
REQ-031 Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates at neither bound by construction and never exceeds DEPTH.

Reset
REQ-032 On rst_n low, immediately set fu_valid = 0, count = 0, head = tail = 0, stall = 0, overflow = 0, primed = 0, ce_q = 0. Buffer contents are not cleared.
REQ-033 Reset asserted mid-operation discards all buffered entries; no dispatch handshake completes on that edge.
REQ-034 Deassertion takes effect at the first rising clk edge after rst_n high. Priming per REQ-020 applies.

Verification
REQ-035 Reset release with in_ce = 1 held -> no enqueue, count = 0; then in_ce -> 0 with in_unit = 2, op = 0x05 -> next cycle fu_valid = 4'b0100, fu_op = 0x05, count = 1.
REQ-036 Push 3 instructions: ALU, MUL, BRU, all fu_ready = 0 -> count = 3, stall = 1 (DEPTH=4). Raise fu_ready = 4'b1111 -> dispatch in order ALU, MUL, BRU on consecutive cycles, fu_valid = 0001, 1000, 0010.
REQ-037 Head targets LSU, fu_ready = 4'b1011 -> fu_valid = 0100 holds, payload stable, no dequeue for 10 cycles.
REQ-038 Fill to 4 entries, then a 5th toggle with no ready -> overflow = 1, count = 4, head payload unchanged. Repeat the case with head unit ready in the same cycle -> accepted, count = 4, overflow = 0.
REQ-039 Push 6 instructions with tags 0..5 while draining continuously, 1 push and 1 pop per cycle -> fu_tag sequence 0..5 is observed across pointer wrap.
REQ-040 Assert rst_n = 0 asynchronously between clock edges with count = 3 -> fu_valid = 0, count = 0, stall = 0 without waiting for clk.

Source files
------------

// File: rtl/ex_dispatch.sv
// ============================================================================
// ex_dispatch : in-order EX dispatch FIFO fed by a toggle strobe, one valid
//               unit per cycle from the head entry.          Rev 1.0
// ============================================================================
`default_nettype none

module ex_dispatch #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_ce,
  input  logic [1:0]                in_unit,
  input  logic [2*XLEN-1:0]         in_val,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [OP_W-1:0]           in_op,
  input  logic [TAG_W-1:0]          in_target,
  input  logic [3:0]                fu_ready,
  output logic [3:0]                fu_valid,
  output logic [OP_W-1:0]           fu_op,
  output logic [2*XLEN-1:0]         fu_val,
  output logic [TAG_W-1:0]          fu_tag,
  output logic [TAG_W-1:0]          fu_target,
  output logic                      stall,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned c_pw = $clog2(DEPTH);
  localparam int unsigned c_cw = c_pw + 1;
  localparam logic [c_cw-1:0] c_full      = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_stall_lvl = c_cw'(DEPTH - 1);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
  localparam logic [c_pw-1:0] c_ptr_one   = c_pw'(1);

  logic [1:0]        r_unit_mem   [DEPTH];
  logic [2*XLEN-1:0] r_val_mem    [DEPTH];
  logic [TAG_W-1:0]  r_tag_mem    [DEPTH];
  logic [OP_W-1:0]   r_op_mem     [DEPTH];
  logic [TAG_W-1:0]  r_target_mem [DEPTH];

  logic            r_ce_q;
  logic            r_primed;
  logic [c_pw-1:0] r_head;
  logic [c_pw-1:0] r_tail;
  logic [c_cw-1:0] r_count;
  logic            r_stall;
  logic            r_overflow;

  logic [3:0]      w_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_enq;
  logic            w_drop;
  logic [c_cw-1:0] w_count_nxt;

  // Head unit selects the single valid line; empty buffer drives none.
  always_comb begin
    w_valid = 4'b0000;
    if (r_count != '0) begin
      w_valid[r_unit_mem[r_head]] = 1'b1;
    end
  end

  assign w_push = r_primed & (in_ce ^ r_ce_q);
  assign w_pop  = |(w_valid & fu_ready);
  assign w_full = (r_count == c_full);
  // A full buffer still accepts when the head leaves on the same edge.
  assign w_enq  = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_q     <= 1'b0;
      r_primed   <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ce_q   <= in_ce;
      r_primed <= 1'b1;
      if (w_enq) begin
        r_tail <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
      end
      r_count <= w_count_nxt;
      r_stall <= (w_count_nxt >= c_stall_lvl);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_unit_mem[r_tail]   <= in_unit;
      r_val_mem[r_tail]    <= in_val;
      r_tag_mem[r_tail]    <= in_tag;
      r_op_mem[r_tail]     <= in_op;
      r_target_mem[r_tail] <= in_target;
    end
  end

  assign fu_valid  = w_valid;
  assign fu_op     = r_op_mem[r_head];
  assign fu_val    = r_val_mem[r_head];
  assign fu_tag    = r_tag_mem[r_head];
  assign fu_target = r_target_mem[r_head];
  assign stall     = r_stall;
  assign overflow  = r_overflow;
  assign count     = r_count;

endmodule

`default_nettype wire
